estagio_busca: RTL

Instruction-fetch stage upstream of the BIOS ROM and the instruction memory. Owns the program counter. Drives the address to the BIOS ROM while in boot mode and to instruction memory afterwards. Registers the fetched word into an instruction register for the decoder. Handles jumps, stalls, the BIOS-exit handoff and halt.

---
 rtl/estagio_busca_pkg.sv | 16 +
 rtl/estagio_busca_contador_programa.sv | 35 +++
 rtl/estagio_busca.sv | 125 ++++++++++++
 3 files changed

// File: rtl/estagio_busca_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package estagio_busca_pkg;

    localparam int unsigned PC_WIDTH    = 26;
    localparam int unsigned BIOS_SIZE   = 52;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        BIOS    = 2'd0,
        MEMORIA = 2'd1,
        PARADO  = 2'd2
    } estado_t;

endpackage

// File: rtl/estagio_busca_contador_programa.sv
// Program counter register: load has priority over increment, otherwise hold.
// Increment wraps modulo 2^WIDTH.
module contador_programa
    import estagio_busca_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             carrega,
    input  logic             incrementa,
    input  logic [WIDTH-1:0] valor_carga,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc;
        if (carrega) begin
            pc_d = valor_carga;
        end else if (incrementa) begin
            pc_d = pc + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the pc, fetches from BIOS ROM in boot mode and from
// instruction memory afterwards, and registers the word for the decoder.
module estagio_busca
    import estagio_busca_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   desvio,
    input  logic [PC_WIDTH-1:0]    alvo_desvio,
    input  logic                   sai_bios,
    input  logic                   halt,
    input  logic [INSTR_WIDTH-1:0] bios_instrucao,
    input  logic [INSTR_WIDTH-1:0] mem_instrucao,
    input  logic                   mem_pronta,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   mem_leitura,
    output logic [INSTR_WIDTH-1:0] instrucao,
    output logic                   instrucao_valida,
    output logic                   modo_bios,
    output logic                   parado
);

    localparam logic [PC_WIDTH-1:0] BIOS_FIM = PC_WIDTH'(BIOS_SIZE);

    estado_t                estado_q, estado_d;
    logic [INSTR_WIDTH-1:0] instrucao_d;
    logic                   valida_d;
    logic                   modo_bios_d;
    logic                   carrega;
    logic                   incrementa;
    logic [PC_WIDTH-1:0]    valor_carga;

    contador_programa #(
        .WIDTH (PC_WIDTH)
    ) u_contador_programa (
        .clock       (clock),
        .reset       (reset),
        .carrega     (carrega),
        .incrementa  (incrementa),
        .valor_carga (valor_carga),
        .pc          (pc)
    );

    always_comb begin
        estado_d    = estado_q;
        instrucao_d = instrucao;
        valida_d    = instrucao_valida;
        modo_bios_d = modo_bios;
        carrega     = 1'b0;
        incrementa  = 1'b0;
        valor_carga = alvo_desvio;

        case (estado_q)
            BIOS: begin
                if (halt) begin
                    estado_d = PARADO;
                    valida_d = 1'b0;
                end else if (sai_bios) begin
                    estado_d    = MEMORIA;
                    modo_bios_d = 1'b0;
                    valida_d    = 1'b0;
                    carrega     = 1'b1;
                    valor_carga = '0;
                end else if (desvio) begin
                    carrega  = 1'b1;
                    valida_d = 1'b0;
                end else if (stall) begin
                    valida_d = instrucao_valida;
                end else if (pc >= BIOS_FIM) begin
                    // Fetch beyond the ROM is fatal: flush and halt the core.
                    estado_d    = PARADO;
                    instrucao_d = NOP;
                    valida_d    = 1'b0;
                end else begin
                    instrucao_d = bios_instrucao;
                    valida_d    = 1'b1;
                    incrementa  = 1'b1;
                end
            end
            MEMORIA: begin
                if (halt) begin
                    estado_d = PARADO;
                    valida_d = 1'b0;
                end else if (desvio) begin
                    carrega  = 1'b1;
                    valida_d = 1'b0;
                end else if (stall) begin
                    valida_d = instrucao_valida;
                end else if (mem_pronta) begin
                    instrucao_d = mem_instrucao;
                    valida_d    = 1'b1;
                    incrementa  = 1'b1;
                end else begin
                    valida_d = 1'b0;
                end
            end
            PARADO: begin
                valida_d = 1'b0;
            end
            default: begin
                estado_d = PARADO;
                valida_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q         <= BIOS;
            instrucao        <= NOP;
            instrucao_valida <= 1'b0;
            modo_bios        <= 1'b1;
        end else begin
            estado_q         <= estado_d;
            instrucao        <= instrucao_d;
            instrucao_valida <= valida_d;
            modo_bios        <= modo_bios_d;
        end
    end

    assign mem_leitura = (estado_q == MEMORIA);
    assign parado      = (estado_q == PARADO);

endmodule
